alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: instruction queue entries, power of two, minimum 2.
REQ-002 Parameter MULDIV_WAIT, default 2: extra settle cycles granted to mul/div before the result is captured.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  producer presents an instruction.
REQ-006 in_ready  output  1  queue can accept; equals not-full.
REQ-007 in_instr  input  instr_t  opcode, operand type, opr_a, opr_b.
REQ-008 alu_iw  output  instr_t  registered instruction word driven to the shared combinational ALU.
REQ-009 alu_result  input  l_data_t  64-bit ALU result.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_result  output  64  captured result.
REQ-013 out_op  output  3  opcode of the reported instruction.
REQ-014 out_err  output  1  illegal opcode or divide-by-zero.
REQ-015 busy  output  1  high whenever the FSM is not IDLE or the queue is non-empty.

Function
REQ-016 A push occurs on a rising edge with in_valid and in_ready high; a queue entry is popped only on the EXEC-to-DONE or IDLE-to-DONE transition.
REQ-017 in_ready derives from the registered count only; when the queue is full, a push is refused even if a pop occurs on the same edge.
REQ-018 Simultaneous push and pop with the queue neither full nor empty leaves the count unchanged, and wrap-around of the read and write pointers is transparent.
REQ-019 FSM states: IDLE, EXEC, DONE.
REQ-020 IDLE with the queue non-empty and a legal head: load the head into alu_iw, load wait_cnt with MULDIV_WAIT for mul/div or 0 otherwise, and go to EXEC.
REQ-021 IDLE with an illegal head opcode (3'b110 or 3'b111), or div with opr_b == 0: do not load alu_iw, set out_result = 0 and out_err = 1, pop the entry, and go to DONE.
REQ-022 EXEC with wait_cnt > 0: decrement wait_cnt and hold alu_iw stable.
REQ-023 EXEC with wait_cnt == 0: capture alu_result into out_result, capture the opcode into out_op, set out_err = 0, pop the entry, and go to DONE.
REQ-024 DONE: out_valid = 1, and out_result, out_op and out_err are held stable until out_ready.
REQ-025 DONE with out_ready: go to EXEC directly if the next queue head is legal, apply the REQ-021 path if it is not, and go to IDLE if the queue is empty.
REQ-026 Latency, with the queue empty and out_ready high: out_valid rises on the 2nd rising edge after acceptance for add/sub/sl/sr and on the (2 + MULDIV_WAIT)th for mul/div.
REQ-027 Results leave in acceptance order, with no reordering and no drops.

Reset
REQ-028 While rst_n is low: FSM = IDLE, queue empty, alu_iw = 0, out_valid = 0, out_result = 0, out_op = 0, out_err = 0, wait_cnt = 0, busy = 0, and in_ready = 1 once reset is released.
REQ-029 Reset mid-EXEC or mid-DONE discards all queued and in-flight instructions, and no out_valid pulse follows the release of reset.

Structure
REQ-030 opcode_t, operand_type_t, data_t, l_data_t and instr_t reside in the shared package alu_pkg, which is imported by the ALU, this block and the benches.
REQ-031 The queue is a separate sub-module, alu_instr_fifo, parameterized by depth and element type instr_t; the FSM and output registers stay in alu_issue_ctrl.

Verification
REQ-032 Push add, a = 0x10, b = 0x20, out_ready = 1 -> out_valid rises 2 edges after acceptance, with out_result = 0x30, out_op = add, out_err = 0.
REQ-033 Push mul, a = 7, b = 6, MULDIV_WAIT = 2 -> alu_iw is stable for 3 EXEC cycles, then out_result = 42 arrives 4 edges after acceptance.
REQ-034 Push div with b = 0, then opcode 3'b111 -> two results, each with out_err = 1 and out_result = 0, and alu_iw is never loaded with them.
REQ-035 Hold out_ready = 0 and push 5 instructions (FIFO_DEPTH = 4) -> in_ready falls after 4 are queued plus 1 is in flight, and releasing out_ready drains all 5 in order.
REQ-036 Assert rst_n = 0 during mul EXEC with 2 entries queued -> all outputs are 0 immediately, busy = 0, and no result appears after release.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and opcode helpers
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3,
      OP_SL  = 3'd4,
      OP_SR  = 3'd5
   } opcode_t;

   typedef enum logic {
      OPT_UNSIGNED = 1'b0,
      OPT_SIGNED   = 1'b1
   } operand_type_t;

   typedef logic [31:0] data_t;
   typedef logic [63:0] l_data_t;

   typedef struct packed {
      opcode_t       op;
      operand_type_t typ;
      data_t         a;
      data_t         b;
   } instr_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } issue_state_t;

   // Encodings 6 and 7 are unassigned; a zero divisor is rejected before it reaches the ALU.
   function automatic logic op_is_legal(input instr_t i);
      return (3'(i.op) < 3'd6) && !((i.op == OP_DIV) && (i.b == '0));
   endfunction

   function automatic logic op_is_muldiv(input instr_t i);
      return (i.op == OP_MUL) || (i.op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_instr_fifo.sv
// rtl/alu_instr_fifo.sv - instruction queue with power-of-two depth
module alu_instr_fifo
   import alu_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = instr_t
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_push,
   input  T     i_data,
   input  logic i_pop,
   output T     o_head,
   output logic o_empty,
   output logic o_full
);

   localparam int AW = $clog2(DEPTH);

   T               r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [AW:0]    r_count;
   logic           w_push;
   logic           w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   // A full queue refuses the push even when a pop lands on the same edge.
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - queues instructions, issues them to a shared ALU, reports results
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int MULDIV_WAIT = 2
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  instr_t      in_instr,
   output instr_t      alu_iw,
   input  l_data_t     alu_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result,
   output logic [2:0]  out_op,
   output logic        out_err,
   output logic        busy
);

   localparam int WW = (MULDIV_WAIT < 1) ? 1 : $clog2(MULDIV_WAIT + 1);

   issue_state_t  r_state;
   instr_t        r_iw;
   logic [WW-1:0] r_wait;
   logic [63:0]   r_result;
   logic [2:0]    r_op;
   logic          r_err;

   issue_state_t  w_state_nxt;
   instr_t        w_iw_nxt;
   logic [WW-1:0] w_wait_nxt;
   logic [63:0]   w_result_nxt;
   logic [2:0]    w_op_nxt;
   logic          w_err_nxt;
   logic          w_pop;
   logic          w_dispatch;
   instr_t        w_head;
   logic          w_empty;
   logic          w_full;

   alu_instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (instr_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (in_valid),
      .i_data  (in_instr),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign in_ready   = !w_full;
   assign alu_iw     = r_iw;
   assign out_valid  = (r_state == ST_DONE);
   assign out_result = r_result;
   assign out_op     = r_op;
   assign out_err    = r_err;
   assign busy       = (r_state != ST_IDLE) || !w_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_iw     <= '0;
         r_wait   <= '0;
         r_result <= '0;
         r_op     <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_iw     <= w_iw_nxt;
         r_wait   <= w_wait_nxt;
         r_result <= w_result_nxt;
         r_op     <= w_op_nxt;
         r_err    <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_iw_nxt     = r_iw;
      w_wait_nxt   = r_wait;
      w_result_nxt = r_result;
      w_op_nxt     = r_op;
      w_err_nxt    = r_err;
      w_pop        = 1'b0;
      w_dispatch   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_dispatch = !w_empty;
         end
         ST_EXEC: begin
            // The in-flight instruction stays at the queue head until its result is captured.
            if (r_wait != '0) begin
               w_wait_nxt = r_wait - 1'b1;
            end else begin
               w_result_nxt = alu_result;
               w_op_nxt     = 3'(r_iw.op);
               w_err_nxt    = 1'b0;
               w_pop        = 1'b1;
               w_state_nxt  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               if (w_empty) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_dispatch = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_dispatch) begin
         if (op_is_legal(w_head)) begin
            w_iw_nxt    = w_head;
            w_wait_nxt  = op_is_muldiv(w_head) ? WW'(MULDIV_WAIT) : '0;
            w_state_nxt = ST_EXEC;
         end else begin
            w_result_nxt = '0;
            w_op_nxt     = 3'(w_head.op);
            w_err_nxt    = 1'b1;
            w_pop        = 1'b1;
            w_state_nxt  = ST_DONE;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   typedef struct {
      logic [63:0] res;
      logic [2:0]  op;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   instr_t      in_instr;
   instr_t      alu_iw;
   l_data_t     alu_result;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic [2:0]  out_op;
   logic        out_err;
   logic        busy;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   exp_t m_e;

   alu_issue_ctrl #(
      .FIFO_DEPTH  (4),
      .MULDIV_WAIT (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .alu_iw     (alu_iw),
      .alu_result (alu_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_op     (out_op),
      .out_err    (out_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU driven by the issued instruction word.
   always_comb begin
      alu_result = '0;
      case (alu_iw.op)
         OP_ADD:  alu_result = 64'(alu_iw.a) + 64'(alu_iw.b);
         OP_SUB:  alu_result = 64'(alu_iw.a) - 64'(alu_iw.b);
         OP_MUL:  alu_result = 64'(alu_iw.a) * 64'(alu_iw.b);
         OP_DIV:  alu_result = (alu_iw.b == '0) ? 64'd0 : 64'(alu_iw.a / alu_iw.b);
         OP_SL:   alu_result = 64'(alu_iw.a) << alu_iw.b[5:0];
         OP_SR:   alu_result = 64'(alu_iw.a >> alu_iw.b[4:0]);
         default: alu_result = '0;
      endcase
   end

   function automatic instr_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      instr_t t;
      t.op  = opcode_t'(op);
      t.typ = OPT_UNSIGNED;
      t.a   = a;
      t.b   = b;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input instr_t ins, input logic [63:0] res, input logic err);
      int t;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = ins;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         check("push_timeout", 64'(in_ready), 64'd1);
      end
      @(posedge clk);
      e.res = res;
      e.op  = 3'(ins.op);
      e.err = err;
      exp_q.push_back(e);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) begin
         check("drain_timeout", 64'(exp_q.size()), 64'd0);
      end
   endtask

   task automatic measure(input instr_t ins, output int edges, output int stable);
      edges  = 0;
      stable = 0;
      while (edges < 50) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (out_valid) break;
         if (alu_iw == ins) stable++;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result: got result 0x%0h op %0d err %0b, expected none",
                     out_result, out_op, out_err);
         end else begin
            m_e = exp_q.pop_front();
            check("out_result", out_result, m_e.res);
            check("out_op", 64'(out_op), 64'(m_e.op));
            check("out_err", 64'(out_err), 64'(m_e.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int stab;
      int vcnt;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_alu_iw", 64'(alu_iw), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_result", out_result, 64'd0);
      check("rst_out_op", 64'(out_op), 64'd0);
      check("rst_out_err", 64'(out_err), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // add latency
      push(mk(OP_ADD, 32'h10, 32'h20), 64'h30, 1'b0);
      measure(mk(OP_ADD, 32'h10, 32'h20), lat, stab);
      check("add_latency", 64'(lat), 64'd2);
      wait_drain();

      // mul latency and issue-word stability
      push(mk(OP_MUL, 32'd7, 32'd6), 64'd42, 1'b0);
      measure(mk(OP_MUL, 32'd7, 32'd6), lat, stab);
      check("mul_latency", 64'(lat), 64'd4);
      check("mul_iw_stable", 64'(stab), 64'd3);
      wait_drain();

      // divide-by-zero and illegal opcode
      push(mk(OP_DIV, 32'd9, 32'd0), 64'd0, 1'b1);
      push(mk(3'b111, 32'd1, 32'd2), 64'd0, 1'b1);
      wait_drain();
      check("illegal_iw_untouched", 64'(alu_iw), 64'(mk(OP_MUL, 32'd7, 32'd6)));

      // backpressure: one in flight plus a full queue
      out_ready = 1'b0;
      push(mk(OP_SUB, 32'd100, 32'd1), 64'd99, 1'b0);
      push(mk(OP_SL, 32'd1, 32'd4), 64'd16, 1'b0);
      push(mk(OP_SR, 32'h80, 32'd3), 64'h10, 1'b0);
      push(mk(OP_DIV, 32'd100, 32'd7), 64'd14, 1'b0);
      @(negedge clk);
      check("bp_ready_after4", 64'(in_ready), 64'd1);
      push(mk(OP_ADD, 32'd5, 32'd5), 64'd10, 1'b0);
      @(negedge clk);
      check("bp_ready_full", 64'(in_ready), 64'd0);
      check("bp_valid_held", 64'(out_valid), 64'd1);
      repeat (3) @(negedge clk);
      check("bp_result_held", out_result, 64'd99);
      check("bp_queue_len", 64'(exp_q.size()), 64'd5);
      out_ready = 1'b1;
      wait_drain();
      check("bp_ready_drained", 64'(in_ready), 64'd1);

      // reset during a mul EXEC with two more queued
      push(mk(OP_MUL, 32'd3, 32'd5), 64'd15, 1'b0);
      push(mk(OP_ADD, 32'd1, 32'd1), 64'd2, 1'b0);
      push(mk(OP_SUB, 32'd9, 32'd4), 64'd5, 1'b0);
      check("mid_exec_iw", 64'(alu_iw), 64'(mk(OP_MUL, 32'd3, 32'd5)));
      check("mid_exec_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_alu_iw", 64'(alu_iw), 64'd0);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_out_result", out_result, 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) vcnt++;
      end
      check("post_rst_no_valid", 64'(vcnt), 64'd0);
      check("post_rst_busy", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
